player_damage_ctl: RTL and testbench
====================================

Name: player_damage_ctl

Overview:
- Sits directly downstream of the obstacles stage; consumes its 36-bit obstacle_data and its 28-bit delayed timing bundle.
- Per pixel, detects overlap of a lit obstacle pixel with the player box anchored at the mouse position.
- Per frame, applies damage, runs an invulnerability window and tracks player HP.
- Raises game_over to the game FSM.

Parameters:
- PLAYER_SIZE, 16: player box side in pixels; box spans [xpos, xpos+PLAYER_SIZE-1] x [ypos, ypos+PLAYER_SIZE-1].
- BG_COLOR, 12'h000: obstacle rgb value treated as "no obstacle".
- MAX_HP, 8'd100: HP loaded on play_selected.
- DAMAGE, 8'd10: HP removed per hit frame.
- INVULN_FRAMES, 6'd60: frames of immunity after a hit.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-low.
- delayed_signals  in  28  {vcount[27:16], vsync[15], vblnk[14], hcount[13:2], hsync[1], hblnk[0]}.
- obstacle_data  in  36  {obstacle_x[35:24], obstacle_y[23:12], rgb[11:0]}; only rgb is used here.
- xpos  in  12  player box left edge.
- ypos  in  12  player box top edge.
- game_on  in  1  high while gameplay is active.
- play_selected  in  1  pulse: new game start.
- hp  out  8  current HP.
- hit  out  1  one-cycle pulse when damage is applied.
- invuln  out  1  high during the invulnerability window.
- game_over  out  1  one-cycle pulse when HP reaches 0.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, hp=0, hit=0, invuln=0, game_over=0, frame_hit=0, invuln_cnt=0, vsync_d=0.
- Pixel compare stage, 1-cycle registered: px_hit <= !hblnk && !vblnk && rgb!=BG_COLOR && hcount>=xpos && hcount<xpos+PLAYER_SIZE && vcount>=ypos && vcount<ypos+PLAYER_SIZE.
  - Sums use 13-bit arithmetic so xpos near 4095 does not wrap.
- frame_hit is a sticky OR of px_hit. It clears on the frame tick after being consumed.
- Frame tick = vsync rising edge (vsync && !vsync_d). All HP and invuln updates happen only on the tick; pixels compared in the tick cycle count toward the next frame.
- FSM states and transitions:
  - IDLE: hp held. play_selected -> ARMED, hp<=MAX_HP, frame_hit<=0, invuln_cnt<=0.
  - ARMED: on tick with game_on && frame_hit:
    - hp<=hp-DAMAGE, saturating at 0.
    - hit pulses 1 cycle.
    - If new hp==0 -> DEAD, game_over pulses in the same cycle as hit.
    - Else -> INVULN, invuln_cnt<=INVULN_FRAMES-1, invuln=1.
  - INVULN: frame_hit ignored and cleared on each tick. Each tick: if invuln_cnt==0 -> ARMED, invuln=0; else invuln_cnt-1.
  - DEAD: hp=0, no outputs pulse. play_selected -> ARMED with hp<=MAX_HP.
- game_on low: ticks do not change HP or the invuln counter; frame_hit still clears on each tick.
- play_selected in any state, including mid-INVULN, restarts to ARMED with hp=MAX_HP and invuln=0. It has priority over a simultaneous tick.
- DAMAGE >= MAX_HP: the first hit goes straight to DEAD.
- Outputs are registered. A tick at cycle T drives hit/game_over/hp updates visible at T+1.

Decomposition:
- Shared package game_pkg:
  - delayed_signals field offsets (VCOUNT_MSB/LSB, VSYNC_BIT, VBLNK_BIT, HCOUNT_MSB/LSB, HSYNC_BIT, HBLNK_BIT).
  - obstacle_data field offsets (OBS_X, OBS_Y, OBS_RGB slices).
  - FSM state encodings ST_IDLE, ST_ARMED, ST_INVULN, ST_DEAD (2 bits).
- One sub-module: player_box_hit. It contains the registered pixel-versus-box compare, parameterised by PLAYER_SIZE and BG_COLOR. The FSM and counters live in the top.

Test Plan:
- Release rst, pulse play_selected -> hp=100, state ARMED, invuln=0, no hit.
- xpos=ypos=200, obstacle rgb=12'hfff only at pixel (205,210), game_on=1 -> at next vsync tick hit pulses once, hp=90, invuln=1 for exactly 60 ticks, then 0.
- Same overlap every frame -> hp drops 10 only every 61st frame; reaching 0 gives hit and game_over in the same cycle, hp stays 0, state DEAD.
- Lit obstacle pixel only during hblnk, or rgb=BG_COLOR inside the box, or pixel at x=216 with xpos=200 -> no hit, hp unchanged.
- Pulse play_selected on the same cycle as a hit tick during INVULN -> hp=100, invuln=0, hit=0.
- Assert rst=0 mid-INVULN -> next cycle hp=0, invuln=0, state IDLE; xpos=4090 with hcount=4095 hit checks correctly with no wrap.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game pipeline stages.
// Field offsets of the delayed timing bundle and the obstacle data word,
// plus the state encoding of the player damage controller.
package game_pkg;

  // delayed_signals = {vcount, vsync, vblnk, hcount, hsync, hblnk}
  localparam int VCOUNT_MSB = 27;
  localparam int VCOUNT_LSB = 16;
  localparam int VSYNC_BIT  = 15;
  localparam int VBLNK_BIT  = 14;
  localparam int HCOUNT_MSB = 13;
  localparam int HCOUNT_LSB = 2;
  localparam int HSYNC_BIT  = 1;
  localparam int HBLNK_BIT  = 0;

  // obstacle_data = {obstacle_x, obstacle_y, rgb}
  localparam int OBS_X_MSB   = 35;
  localparam int OBS_X_LSB   = 24;
  localparam int OBS_Y_MSB   = 23;
  localparam int OBS_Y_LSB   = 12;
  localparam int OBS_RGB_MSB = 11;
  localparam int OBS_RGB_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_INVULN = 2'd2,
    ST_DEAD   = 2'd3
  } dmg_state_e;

endpackage

// File: rtl/player_box_hit.sv
// Registered per-pixel overlap test between a lit obstacle pixel and the
// player box [xpos, xpos+PLAYER_SIZE-1] x [ypos, ypos+PLAYER_SIZE-1].
// Ports:
//   clk, rst       pixel clock, synchronous active-low reset
//   hcount_i       current pixel column
//   vcount_i       current pixel row
//   hblnk_i        horizontal blanking
//   vblnk_i        vertical blanking
//   rgb_i          obstacle colour at this pixel
//   xpos_i, ypos_i player box top-left corner
//   px_hit_o       overlap of the previous pixel (1-cycle latency)
module player_box_hit #(
  parameter int          PLAYER_SIZE = 16,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hcount_i,
  input  logic [11:0] vcount_i,
  input  logic        hblnk_i,
  input  logic        vblnk_i,
  input  logic [11:0] rgb_i,
  input  logic [11:0] xpos_i,
  input  logic [11:0] ypos_i,
  output logic        px_hit_o
);

  // Upper box edges are formed in 13 bits so a box hugging the right or
  // bottom edge of the 12-bit coordinate space does not wrap to zero.
  logic [12:0] x_hi;
  logic [12:0] y_hi;
  logic        in_x;
  logic        in_y;
  logic        px_hit_d;
  logic        px_hit_q;

  assign x_hi = {1'b0, xpos_i} + 13'(PLAYER_SIZE);
  assign y_hi = {1'b0, ypos_i} + 13'(PLAYER_SIZE);

  assign in_x = (hcount_i >= xpos_i) && ({1'b0, hcount_i} < x_hi);
  assign in_y = (vcount_i >= ypos_i) && ({1'b0, vcount_i} < y_hi);

  assign px_hit_d = !hblnk_i && !vblnk_i && (rgb_i != BG_COLOR) && in_x && in_y;

  always_ff @(posedge clk) begin
    if (!rst) px_hit_q <= 1'b0;
    else      px_hit_q <= px_hit_d;
  end

  assign px_hit_o = px_hit_q;

endmodule

// File: rtl/player_damage_ctl.sv
// Player damage controller: collects per-pixel overlaps into a per-frame
// hit flag, then on each frame tick (vsync rising edge) applies damage,
// runs the invulnerability window and tracks HP.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset, no game running, HP held
// ST_ARMED  | game running, a hit frame costs DAMAGE HP
// ST_INVULN | immune after a hit, invuln_cnt counts remaining ticks
// ST_DEAD   | HP exhausted, waiting for a new game
//
// Ports:
//   clk, rst         pixel clock, synchronous active-low reset
//   delayed_signals  {vcount, vsync, vblnk, hcount, hsync, hblnk}
//   obstacle_data    {obstacle_x, obstacle_y, rgb}; only rgb used
//   xpos, ypos       player box top-left corner
//   game_on          gameplay active; ticks are ignored while low
//   play_selected    new game pulse, overrides everything else
//   hp               current HP
//   hit              1-cycle pulse when damage is applied
//   invuln           high during the invulnerability window
//   game_over        1-cycle pulse when HP reaches 0
module player_damage_ctl
  import game_pkg::*;
#(
  parameter int          PLAYER_SIZE   = 16,
  parameter logic [11:0] BG_COLOR      = 12'h000,
  parameter logic [7:0]  MAX_HP        = 8'd100,
  parameter logic [7:0]  DAMAGE        = 8'd10,
  parameter logic [5:0]  INVULN_FRAMES = 6'd60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] delayed_signals,
  input  logic [35:0] obstacle_data,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        game_on,
  input  logic        play_selected,
  output logic [7:0]  hp,
  output logic        hit,
  output logic        invuln,
  output logic        game_over
);

  dmg_state_e  state_q, state_d;
  logic [7:0]  hp_q, hp_d;
  logic        hit_q, hit_d;
  logic        invuln_q, invuln_d;
  logic        game_over_q, game_over_d;
  logic        frame_hit_q, frame_hit_d;
  logic [5:0]  invuln_cnt_q, invuln_cnt_d;
  logic        vsync_q;

  logic        vsync;
  logic        tick;
  logic        px_hit;
  logic [7:0]  hp_after;
  logic        unused_fields;

  assign vsync    = delayed_signals[VSYNC_BIT];
  assign tick     = vsync && !vsync_q;
  assign hp_after = (hp_q > DAMAGE) ? hp_q - DAMAGE : 8'd0;

  assign unused_fields = ^{obstacle_data[OBS_X_MSB:OBS_Y_LSB], delayed_signals[HSYNC_BIT]};

  player_box_hit #(
    .PLAYER_SIZE (PLAYER_SIZE),
    .BG_COLOR    (BG_COLOR)
  ) u_box_hit (
    .clk      (clk),
    .rst      (rst),
    .hcount_i (delayed_signals[HCOUNT_MSB:HCOUNT_LSB]),
    .vcount_i (delayed_signals[VCOUNT_MSB:VCOUNT_LSB]),
    .hblnk_i  (delayed_signals[HBLNK_BIT]),
    .vblnk_i  (delayed_signals[VBLNK_BIT]),
    .rgb_i    (obstacle_data[OBS_RGB_MSB:OBS_RGB_LSB]),
    .xpos_i   (xpos),
    .ypos_i   (ypos),
    .px_hit_o (px_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      hp_q         <= 8'd0;
      hit_q        <= 1'b0;
      invuln_q     <= 1'b0;
      game_over_q  <= 1'b0;
      frame_hit_q  <= 1'b0;
      invuln_cnt_q <= 6'd0;
      vsync_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_q         <= hp_d;
      hit_q        <= hit_d;
      invuln_q     <= invuln_d;
      game_over_q  <= game_over_d;
      frame_hit_q  <= frame_hit_d;
      invuln_cnt_q <= invuln_cnt_d;
      vsync_q      <= vsync;
    end
  end

  always_comb begin
    state_d = state_q;
    if (play_selected) begin
      state_d = ST_ARMED;
    end else if (tick && game_on) begin
      case (state_q)
        ST_ARMED: begin
          if (frame_hit_q) state_d = (hp_after == 8'd0) ? ST_DEAD : ST_INVULN;
        end
        ST_INVULN: begin
          if (invuln_cnt_q == 6'd0) state_d = ST_ARMED;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // The tick that consumes frame_hit also clears it, so overlaps seen in
  // the tick cycle itself land in the next frame.
  always_comb begin
    hp_d         = hp_q;
    hit_d        = 1'b0;
    game_over_d  = 1'b0;
    invuln_d     = invuln_q;
    invuln_cnt_d = invuln_cnt_q;
    frame_hit_d  = frame_hit_q | px_hit;
    if (play_selected) begin
      hp_d         = MAX_HP;
      invuln_d     = 1'b0;
      invuln_cnt_d = 6'd0;
      frame_hit_d  = 1'b0;
    end else if (tick) begin
      frame_hit_d = 1'b0;
      if (game_on) begin
        case (state_q)
          ST_ARMED: begin
            if (frame_hit_q) begin
              hp_d  = hp_after;
              hit_d = 1'b1;
              if (hp_after == 8'd0) begin
                game_over_d = 1'b1;
              end else begin
                invuln_d     = 1'b1;
                invuln_cnt_d = INVULN_FRAMES - 6'd1;
              end
            end
          end
          ST_INVULN: begin
            if (invuln_cnt_q == 6'd0) invuln_d = 1'b0;
            else                      invuln_cnt_d = invuln_cnt_q - 6'd1;
          end
          ST_DEAD:  hp_d = 8'd0;
          default:  hp_d = hp_q;
        endcase
      end
    end
  end

  assign hp        = hp_q;
  assign hit       = hit_q;
  assign invuln    = invuln_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_player_damage_ctl.sv
module tb_player_damage_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] delayed_signals;
  logic [35:0] obstacle_data;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        game_on;
  logic        play_selected;
  logic [7:0]  hp;
  logic        hit;
  logic        invuln;
  logic        game_over;

  always #5 clk = ~clk;

  player_damage_ctl dut (
    .clk             (clk),
    .rst             (rst),
    .delayed_signals (delayed_signals),
    .obstacle_data   (obstacle_data),
    .xpos            (xpos),
    .ypos            (ypos),
    .game_on         (game_on),
    .play_selected   (play_selected),
    .hp              (hp),
    .hit             (hit),
    .invuln          (invuln),
    .game_over       (game_over)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: frame-level game rules with plain integers.
  int m_hp      = 0;
  bit m_playing = 0;   // a game is running (not idle, not dead)
  int m_immune  = 0;   // ticks of immunity still to serve

  int px_h[$];
  int px_v[$];
  int px_rgb[$];
  bit px_hb[$];
  bit px_vb[$];

  function automatic bit overlaps(int h, int v, int rgb, bit hb, bit vb);
    int xi = int'(xpos);
    int yi = int'(ypos);
    return !hb && !vb && rgb != 0 && h >= xi && h < xi + 16 && v >= yi && v < yi + 16;
  endfunction

  task automatic drive(input int h, input int v, input int rgb, input bit hb, input bit vb, input bit vs);
    delayed_signals = {12'(v), vs, vb, 12'(h), 1'b0, hb};
    obstacle_data   = {12'($urandom), 12'($urandom), 12'(rgb)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_px();
    px_h.delete(); px_v.delete(); px_rgb.delete(); px_hb.delete(); px_vb.delete();
  endtask

  task automatic add_px(input int h, input int v, input int rgb, input bit hb, input bit vb);
    px_h.push_back(h); px_v.push_back(v); px_rgb.push_back(rgb);
    px_hb.push_back(hb); px_vb.push_back(vb);
  endtask

  task automatic single_px(input int h, input int v, input int rgb, input bit hb, input bit vb);
    clear_px();
    add_px(h, v, rgb, hb, vb);
  endtask

  // Plays the pixel list, one blank guard cycle, then a 2-cycle vsync.
  task automatic run_frame(input bit play_tick, input string tag);
    bit fh      = 0;
    int exp_hit = 0;
    int exp_go  = 0;
    foreach (px_h[i]) begin
      drive(px_h[i], px_v[i], px_rgb[i], px_hb[i], px_vb[i], 1'b0);
      if (overlaps(px_h[i], px_v[i], px_rgb[i], px_hb[i], px_vb[i])) fh = 1;
      step();
      chk($sformatf("%s.pix_hit", tag), int'(hit), 0);
    end
    drive(0, 0, 0, 1'b1, 1'b1, 1'b0);
    step();
    play_selected = play_tick;
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1);
    step();
    play_selected = 1'b0;
    if (play_tick) begin
      m_playing = 1; m_hp = 100; m_immune = 0;
    end else if (m_playing && game_on) begin
      if (m_immune > 0) m_immune--;
      else if (fh) begin
        exp_hit = 1;
        m_hp = (m_hp > 10) ? m_hp - 10 : 0;
        if (m_hp == 0) begin
          exp_go = 1; m_playing = 0;
        end else m_immune = 60;
      end
    end
    chk($sformatf("%s.hit", tag), int'(hit), exp_hit);
    chk($sformatf("%s.game_over", tag), int'(game_over), exp_go);
    chk($sformatf("%s.hp", tag), int'(hp), m_hp);
    chk($sformatf("%s.invuln", tag), int'(invuln), (m_immune > 0) ? 1 : 0);
    drive(0, 0, 0, 1'b1, 1'b1, 1'b1);
    step();
    chk($sformatf("%s.hit_after", tag), int'(hit), 0);
    chk($sformatf("%s.go_after", tag), int'(game_over), 0);
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 1'b1, 1'b1, 1'b0);
    step();
  endtask

  task automatic play_pulse(input string tag);
    idle_cycle();
    play_selected = 1'b1;
    step();
    play_selected = 1'b0;
    m_playing = 1; m_hp = 100; m_immune = 0;
    chk($sformatf("%s.hp", tag), int'(hp), 100);
    chk($sformatf("%s.invuln", tag), int'(invuln), 0);
    chk($sformatf("%s.hit", tag), int'(hit), 0);
  endtask

  initial begin
    int frames;
    rst = 1'b0;
    game_on = 1'b0;
    play_selected = 1'b0;
    xpos = 12'd200;
    ypos = 12'd200;
    drive(0, 0, 0, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk("reset.hp", int'(hp), 0);
    chk("reset.hit", int'(hit), 0);
    chk("reset.invuln", int'(invuln), 0);
    chk("reset.game_over", int'(game_over), 0);
    rst = 1'b1;
    idle_cycle();

    play_pulse("start");
    game_on = 1'b1;

    single_px(205, 210, 12'hfff, 1'b0, 1'b0);
    run_frame(1'b0, "first_hit");
    repeat (60) run_frame(1'b0, "invuln_win");

    frames = 0;
    while (m_playing && frames < 1000) begin
      run_frame(1'b0, "to_death");
      frames++;
    end
    chk("death.hp", int'(hp), 0);
    run_frame(1'b0, "dead_hold");

    clear_px();
    run_frame(1'b1, "restart");
    single_px(205, 210, 12'hfff, 1'b1, 1'b0);
    run_frame(1'b0, "hblnk_only");
    single_px(205, 210, 12'h000, 1'b0, 1'b0);
    run_frame(1'b0, "bg_color");
    single_px(216, 210, 12'hfff, 1'b0, 1'b0);
    run_frame(1'b0, "x_216");
    single_px(200, 215, 12'h0f0, 1'b0, 1'b0);
    run_frame(1'b0, "corner_hit");
    single_px(205, 210, 12'hfff, 1'b0, 1'b0);
    run_frame(1'b0, "invuln_a");
    run_frame(1'b1, "play_vs_tick");
    run_frame(1'b0, "hit_again");
    run_frame(1'b0, "invuln_b");

    idle_cycle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    m_playing = 0; m_hp = 0; m_immune = 0;
    chk("mid_rst.hp", int'(hp), 0);
    chk("mid_rst.invuln", int'(invuln), 0);
    chk("mid_rst.hit", int'(hit), 0);
    run_frame(1'b0, "idle_ignore");

    play_pulse("edge_start");
    xpos = 12'd4090;
    ypos = 12'd100;
    single_px(3, 105, 12'hfff, 1'b0, 1'b0);
    run_frame(1'b0, "no_wrap");
    single_px(4095, 105, 12'hfff, 1'b0, 1'b0);
    run_frame(1'b0, "x_4095");
    play_pulse("gameoff_start");
    game_on = 1'b0;
    run_frame(1'b0, "game_off");
    game_on = 1'b1;

    for (int f = 0; f < 900; f++) begin
      int n;
      if (f % 50 == 0) begin
        case ($urandom_range(0, 2))
          0: begin xpos = 12'd200; ypos = 12'd200; end
          1: begin xpos = 12'd4090; ypos = 12'd4088; end
          default: begin xpos = 12'($urandom); ypos = 12'($urandom); end
        endcase
      end
      game_on = ($urandom_range(0, 9) != 0);
      clear_px();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        add_px((int'(xpos) + $urandom_range(0, 40) - 12) & 32'hfff,
               (int'(ypos) + $urandom_range(0, 40) - 12) & 32'hfff,
               ($urandom_range(0, 3) == 0) ? 0 : int'(12'($urandom)),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) == 0));
      end
      run_frame((!m_playing && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
